// File: rtl/control_fsm_pkg.sv
// Shared encodings for the rv32i multicycle sequencer: state codes, datapath mux selects
// and the opcode values the controller dispatches on.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH   = 3'd0,
        STATE_DECODE  = 3'd1,
        STATE_EXECUTE = 3'd2,
        STATE_MEM     = 3'd3,
        STATE_WB      = 3'd4,
        STATE_TRAP    = 3'd5
    } state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

endpackage

// File: rtl/control_fsm_perf_counter.sv
// Enable-gated wrapping retire counter; only built when CTRL_PERF_CNT_EN is defined.
`ifdef CTRL_PERF_CNT_EN
module control_fsm_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/control_fsm.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the rv32i core.
// Optional retire counter on port instret when CTRL_PERF_CNT_EN is defined.
//
// state     | meaning
// FETCH     | imem_req high, wait for imem_ack, load IR
// DECODE    | one cycle, illegal opcode -> TRAP
// EXECUTE   | one cycle, branches retire here
// MEM       | dmem_req high until dmem_ack, stores retire here
// WB        | register writeback and PC update
// TRAP      | sticky fault, left only by rst
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        opcode_valid,
    input  logic        branch_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] instret
`endif
);

    localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             trap_q, trap_d;
    logic             tmo_hit;
    logic             is_store;
    logic             unused_funct3;

    // funct3 is reserved for future CSR decoding
    assign unused_funct3 = ^funct3;

    assign is_store = (opcode == OPC_STORE);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LIMIT);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_PLUS4;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_SEL_ALU;

        case (state_q)
            STATE_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = STATE_DECODE;
                end else if (tmo_hit) begin
                    state_d = STATE_TRAP;
                end
            end
            STATE_DECODE: begin
                state_d = opcode_valid ? STATE_EXECUTE : STATE_TRAP;
            end
            STATE_EXECUTE: begin
                if (is_mem_op(opcode)) begin
                    state_d = STATE_MEM;
                end else if (opcode == OPC_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    state_d = STATE_FETCH;
                end else begin
                    state_d = STATE_WB;
                end
            end
            STATE_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = STATE_FETCH;
                    end else begin
                        state_d = STATE_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = STATE_TRAP;
                end
            end
            STATE_WB: begin
                pc_we   = 1'b1;
                state_d = STATE_FETCH;
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_AUIPC: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_SEL_ALU;
                    end
                    OPC_LOAD: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_SEL_MEM;
                    end
                    OPC_LUI: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_SEL_IMM;
                    end
                    OPC_JAL: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_BRANCH;
                    end
                    OPC_JALR: begin
                        rf_we  = 1'b1;
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_JALR;
                    end
                    OPC_FENCE, OPC_SYSTEM: ;
                    default: ;
                endcase
            end
            STATE_TRAP: begin
                state_d = STATE_TRAP;
            end
            default: begin
                state_d = STATE_TRAP;
            end
        endcase

        // Requests and strobes must be quiet for the whole reset cycle, even mid-access
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = PC_SEL_PLUS4;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            wb_sel   = WB_SEL_ALU;
        end
    end

    // Any state change restarts the wait count; only FETCH/MEM ever compare it
    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if ((MEM_TIMEOUT != 0) &&
                     ((state_q == STATE_FETCH) || (state_q == STATE_MEM))) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign trap_d = (state_d == STATE_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_FETCH;
            tmo_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            trap_q  <= trap_d;
        end
    end

    assign trap  = trap_q & ~rst;
    assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
    control_fsm_perf_counter #(
        .W (32)
    ) u_perf_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (pc_we),
        .count_o (instret)
    );
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected outputs are queued with the stimulus
// and compared at the falling edge. Checks instret too when CTRL_PERF_CNT_EN is defined.
module tb_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       rst;
        logic [2:0] st;
        logic       ireq;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic       dreq;
        logic       dwe;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       trap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       opcode_valid;
    logic       branch_taken;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret;
    logic [31:0] exp_instret = 32'd0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    control_fsm #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .opcode_valid (opcode_valid),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .state        (state)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instret      (instret)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: observed 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t ex(input int st, input int ireq, input int irwe, input int pcwe,
                                input int pcsel, input int dreq, input int dwe, input int rfwe,
                                input int wbsel, input int trp);
        exp_t e;
        e.rst   = 1'b0;
        e.st    = 3'(st);
        e.ireq  = 1'(ireq);
        e.irwe  = 1'(irwe);
        e.pcwe  = 1'(pcwe);
        e.pcsel = 2'(pcsel);
        e.dreq  = 1'(dreq);
        e.dwe   = 1'(dwe);
        e.rfwe  = 1'(rfwe);
        e.wbsel = 2'(wbsel);
        e.trap  = 1'(trp);
        return e;
    endfunction

    function automatic exp_t f_ack();  return ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic exp_t f_wait(); return ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic exp_t dec();    return ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic exp_t exe();    return ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic exp_t trp();    return ex(5, 0, 0, 0, 0, 0, 0, 0, 0, 1); endfunction
    function automatic exp_t quiet(input int st); return ex(st, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction

    // Drive one cycle of stimulus just after the rising edge and queue what it must produce
    task automatic cyc(input logic r, input logic [6:0] op, input logic ov, input logic bt,
                       input logic ia, input logic da, input exp_t e);
        @(posedge clk);
        #1;
        rst          = r;
        opcode       = op;
        opcode_valid = ov;
        branch_taken = bt;
        imem_ack     = ia;
        dmem_ack     = da;
        e.rst        = r;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check_eq("state",    32'(state),    32'(cur.st));
            check_eq("imem_req", 32'(imem_req), 32'(cur.ireq));
            check_eq("ir_we",    32'(ir_we),    32'(cur.irwe));
            check_eq("pc_we",    32'(pc_we),    32'(cur.pcwe));
            check_eq("pc_sel",   32'(pc_sel),   32'(cur.pcsel));
            check_eq("dmem_req", 32'(dmem_req), 32'(cur.dreq));
            check_eq("dmem_we",  32'(dmem_we),  32'(cur.dwe));
            check_eq("rf_we",    32'(rf_we),    32'(cur.rfwe));
            check_eq("wb_sel",   32'(wb_sel),   32'(cur.wbsel));
            check_eq("trap",     32'(trap),     32'(cur.trap));
`ifdef CTRL_PERF_CNT_EN
            check_eq("instret", instret, exp_instret);
            if (cur.rst) exp_instret = 32'd0;
            else if (cur.pcwe) exp_instret = exp_instret + 32'd1;
`endif
        end
    end

    // Acks are held high outside FETCH/MEM to show they are ignored there
    task automatic run_nonmem(input logic [6:0] op, input exp_t wb);
        cyc(0, op, 1, 0, 1, 0, f_ack());
        cyc(0, op, 1, 0, 1, 1, dec());
        cyc(0, op, 1, 0, 1, 1, exe());
        cyc(0, op, 1, 0, 1, 1, wb);
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 7'h00;
        funct3       = 3'b000;
        opcode_valid = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;

        cyc(1, 7'h00, 0, 0, 0, 0, quiet(0));
        cyc(1, 7'h00, 0, 0, 1, 1, quiet(0));

        // ALU / jump / NOP-retire classes
        run_nonmem(OP_OPIMM,  ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        run_nonmem(OP_OP,     ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        run_nonmem(OP_AUIPC,  ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        run_nonmem(OP_LUI,    ex(4, 0, 0, 1, 0, 0, 0, 1, 3, 0));
        run_nonmem(OP_JAL,    ex(4, 0, 0, 1, 1, 0, 0, 1, 2, 0));
        run_nonmem(OP_JALR,   ex(4, 0, 0, 1, 2, 0, 0, 1, 2, 0));
        run_nonmem(OP_FENCE,  ex(4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        run_nonmem(OP_SYSTEM, ex(4, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Load: dmem_ack on the third MEM cycle
        cyc(0, OP_LOAD, 1, 0, 1, 0, f_ack());
        cyc(0, OP_LOAD, 1, 0, 0, 0, dec());
        cyc(0, OP_LOAD, 1, 0, 0, 0, exe());
        cyc(0, OP_LOAD, 1, 0, 0, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc(0, OP_LOAD, 1, 0, 0, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc(0, OP_LOAD, 1, 0, 0, 1, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc(0, OP_LOAD, 1, 0, 0, 0, ex(4, 0, 0, 1, 0, 0, 0, 1, 1, 0));

        // Store: one wait cycle, retires from MEM
        cyc(0, OP_STORE, 1, 0, 1, 0, f_ack());
        cyc(0, OP_STORE, 1, 0, 0, 0, dec());
        cyc(0, OP_STORE, 1, 0, 0, 0, exe());
        cyc(0, OP_STORE, 1, 0, 0, 0, ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        cyc(0, OP_STORE, 1, 0, 0, 1, ex(3, 0, 0, 1, 0, 1, 1, 0, 0, 0));

        // Branch taken, then not taken
        cyc(0, OP_BRANCH, 1, 0, 1, 0, f_ack());
        cyc(0, OP_BRANCH, 1, 0, 0, 0, dec());
        cyc(0, OP_BRANCH, 1, 1, 0, 0, ex(2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        cyc(0, OP_BRANCH, 1, 0, 1, 0, f_ack());
        cyc(0, OP_BRANCH, 1, 0, 0, 0, dec());
        cyc(0, OP_BRANCH, 1, 0, 0, 0, ex(2, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // imem_ack on the limit cycle wins over the timeout
        for (int i = 0; i < 4; i++) cyc(0, OP_OPIMM, 1, 0, 0, 0, f_wait());
        cyc(0, OP_OPIMM, 1, 0, 1, 0, f_ack());
        cyc(0, OP_OPIMM, 1, 0, 0, 0, dec());
        cyc(0, OP_OPIMM, 1, 0, 0, 0, exe());
        cyc(0, OP_OPIMM, 1, 0, 0, 0, ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));

        // Fetch timeout: five unanswered cycles, then TRAP
        for (int i = 0; i < 5; i++) cyc(0, OP_OPIMM, 1, 0, 0, 0, f_wait());
        for (int i = 0; i < 4; i++) cyc(0, OP_OPIMM, 1, 0, 1, 1, trp());
        cyc(1, OP_OPIMM, 1, 0, 0, 0, quiet(5));

        // Data memory timeout on a load
        cyc(0, OP_LOAD, 1, 0, 1, 0, f_ack());
        cyc(0, OP_LOAD, 1, 0, 0, 0, dec());
        cyc(0, OP_LOAD, 1, 0, 0, 0, exe());
        for (int i = 0; i < 5; i++) cyc(0, OP_LOAD, 1, 0, 0, 0, ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc(0, OP_LOAD, 1, 0, 0, 1, trp());
        cyc(1, OP_LOAD, 1, 0, 0, 0, quiet(5));

        // Illegal opcode: trap held for 20 cycles with acks toggling
        cyc(0, 7'h00, 0, 0, 1, 0, f_ack());
        cyc(0, 7'h00, 0, 0, 0, 0, dec());
        for (int i = 0; i < 20; i++) cyc(0, 7'h00, 0, 0, 1'(i), 1'(i + 1), trp());
        cyc(1, 7'h00, 0, 0, 1, 1, quiet(5));

        // Reset during a store: request drops, stale dmem_ack ignored in FETCH
        cyc(0, OP_STORE, 1, 0, 1, 0, f_ack());
        cyc(0, OP_STORE, 1, 0, 0, 0, dec());
        cyc(0, OP_STORE, 1, 0, 0, 0, exe());
        cyc(0, OP_STORE, 1, 0, 0, 0, ex(3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        cyc(1, OP_STORE, 1, 0, 0, 0, quiet(3));
        cyc(0, OP_STORE, 1, 0, 0, 1, f_wait());

        // Three ADDIs back to back
        for (int i = 0; i < 3; i++) run_nonmem(OP_OPIMM, ex(4, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        cyc(0, OP_OPIMM, 1, 0, 0, 0, f_wait());

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) check_eq("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
